// File: rtl/mercury2_dac_scheduler.sv
// Two-requester scheduler in front of the Mercury2 settling-time DAC wrapper.
// Build macro DAC_SCHED_ROUND_ROBIN_EN: tie-break by last-grant pointer instead of fixed channel-0 priority.
module mercury2_dac_scheduler #(
  parameter int BusyTimeout = 16
) (
  input  logic       clk_50MHZ,
  input  logic       reset_n,
  input  logic       wr0,
  input  logic       wr1,
  input  logic [9:0] data0,
  input  logic [9:0] data1,
  output logic       pending0,
  output logic       pending1,
  output logic       done0,
  output logic       done1,
  output logic       overrun0,
  output logic       overrun1,
  output logic       fault,
  input  logic       clear_status,
  output logic       dac_trigger,
  output logic       dac_channel,
  output logic [9:0] dac_din,
  input  logic       dac_busy
);

  localparam int CNT_W = ($clog2(BusyTimeout + 1) < 4) ? 4 : $clog2(BusyTimeout + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BusyTimeout - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [9:0]       hold0_r;
  logic [9:0]       hold1_r;
  logic             grant_s;
  logic             sel_s;
  logic             clr0_s;
  logic             clr1_s;
  logic             ovr0_set_s;
  logic             ovr1_set_s;
  logic             fault_set_s;
`ifdef DAC_SCHED_ROUND_ROBIN_EN
  logic             last_grant_r;
`endif

  assign grant_s     = (state_r == IDLE) && (pending0 || pending1) && !dac_busy;
  assign clr0_s      = grant_s && (sel_s == 1'b0);
  assign clr1_s      = grant_s && (sel_s == 1'b1);
  assign ovr0_set_s  = wr0 && pending0 && !clr0_s;
  assign ovr1_set_s  = wr1 && pending1 && !clr1_s;
  assign fault_set_s = (state_r == WAIT_BUSY) && !dac_busy && (cnt_r == CNT_LAST);

  // Channel selection for the next grant
  always_comb begin
    sel_s = 1'b0;
`ifdef DAC_SCHED_ROUND_ROBIN_EN
    if (pending0 && pending1) begin
      sel_s = ~last_grant_r;
    end else begin
      sel_s = ~pending0;
    end
`else
    if (pending0) begin
      sel_s = 1'b0;
    end else begin
      sel_s = pending1;
    end
`endif
  end

  // Holding registers and pending flags; a write on the grant edge re-arms the channel
  always_ff @(posedge clk_50MHZ or negedge reset_n) begin
    if (!reset_n) begin
      hold0_r  <= 10'd0;
      hold1_r  <= 10'd0;
      pending0 <= 1'b0;
      pending1 <= 1'b0;
    end else begin
      if (wr0) begin
        hold0_r  <= data0;
        pending0 <= 1'b1;
      end else if (clr0_s) begin
        pending0 <= 1'b0;
      end
      if (wr1) begin
        hold1_r  <= data1;
        pending1 <= 1'b1;
      end else if (clr1_s) begin
        pending1 <= 1'b0;
      end
    end
  end

  // Sticky status flags; a new set event beats clear_status on the same edge
  always_ff @(posedge clk_50MHZ or negedge reset_n) begin
    if (!reset_n) begin
      overrun0 <= 1'b0;
      overrun1 <= 1'b0;
      fault    <= 1'b0;
    end else begin
      if (ovr0_set_s) begin
        overrun0 <= 1'b1;
      end else if (clear_status) begin
        overrun0 <= 1'b0;
      end
      if (ovr1_set_s) begin
        overrun1 <= 1'b1;
      end else if (clear_status) begin
        overrun1 <= 1'b0;
      end
      if (fault_set_s) begin
        fault <= 1'b1;
      end else if (clear_status) begin
        fault <= 1'b0;
      end
    end
  end

  // Issue sequencer: grant, trigger pulse, busy handshake and completion pulse
  always_ff @(posedge clk_50MHZ or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      cnt_r        <= '0;
      dac_trigger  <= 1'b0;
      dac_channel  <= 1'b0;
      dac_din      <= 10'd0;
      done0        <= 1'b0;
      done1        <= 1'b0;
`ifdef DAC_SCHED_ROUND_ROBIN_EN
      last_grant_r <= 1'b1;
`endif
    end else begin
      dac_trigger <= 1'b0;
      done0       <= 1'b0;
      done1       <= 1'b0;
      case (state_r)
        IDLE: begin
          if (grant_s) begin
            dac_channel  <= sel_s;
            dac_din      <= sel_s ? hold1_r : hold0_r;
            dac_trigger  <= 1'b1;
            state_r      <= ISSUE;
`ifdef DAC_SCHED_ROUND_ROBIN_EN
            last_grant_r <= sel_s;
`endif
          end else begin
            state_r <= IDLE;
          end
        end
        ISSUE: begin
          cnt_r   <= '0;
          state_r <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (dac_busy) begin
            state_r <= WAIT_DONE;
          end else if (cnt_r == CNT_LAST) begin
            state_r <= IDLE;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        WAIT_DONE: begin
          if (!dac_busy) begin
            if (dac_channel) begin
              done1 <= 1'b1;
            end else begin
              done0 <= 1'b1;
            end
            state_r <= IDLE;
          end else begin
            state_r <= WAIT_DONE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mercury2_dac_scheduler.sv
// Bench for mercury2_dac_scheduler: fixed vector table, directed sequences and random traffic
// checked every cycle against an edge-timeline model of the scheduler and the DAC wrapper.
module tb_mercury2_dac_scheduler;

  logic       clk_50MHZ = 1'b0;
  logic       reset_n = 1'b0;
  logic       wr0 = 1'b0, wr1 = 1'b0, clear_status = 1'b0, dac_busy = 1'b0;
  logic [9:0] data0 = 10'd0, data1 = 10'd0;
  logic       pending0, pending1, done0, done1, overrun0, overrun1, fault;
  logic       dac_trigger, dac_channel;
  logic [9:0] dac_din;

  int checks = 0;
  int errors = 0;

  mercury2_dac_scheduler #(.BusyTimeout(16)) dut (
    .clk_50MHZ(clk_50MHZ), .reset_n(reset_n), .wr0(wr0), .wr1(wr1),
    .data0(data0), .data1(data1), .pending0(pending0), .pending1(pending1),
    .done0(done0), .done1(done1), .overrun0(overrun0), .overrun1(overrun1),
    .fault(fault), .clear_status(clear_status), .dac_trigger(dac_trigger),
    .dac_channel(dac_channel), .dac_din(dac_din), .dac_busy(dac_busy)
  );

  always #5 clk_50MHZ = ~clk_50MHZ;

  function automatic logic [18:0] pk(input logic trig, input logic ch, input logic [9:0] din,
                                     input logic p0, input logic p1, input logic d0, input logic d1,
                                     input logic o0, input logic o1, input logic f);
    return {trig, ch, din, p0, p1, d0, d1, o0, o1, f};
  endfunction

  function automatic logic [18:0] actual();
    return {dac_trigger, dac_channel, dac_din, pending0, pending1, done0, done1,
            overrun0, overrun1, fault};
  endfunction

  task automatic check_vec(input string tag, input int idx, input logic [18:0] exp);
    logic [18:0] act;
    act = actual();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got {trig,ch,din,p0,p1,d0,d1,o0,o1,f}=%b_%b_%h_%b%b_%b%b_%b%b_%b expected %b_%b_%h_%b%b_%b%b_%b%b_%b",
               tag, idx, act[18], act[17], act[16:7], act[6], act[5], act[4], act[3], act[2], act[1], act[0],
               exp[18], exp[17], exp[16:7], exp[6], exp[5], exp[4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  // ---------------- reference model: timeline of grant/done/fault edges ----------------
  int         e = 0;                  // index of the next rising edge
  int         free_at = 0;            // first edge at which a new grant may happen
  int         done_at = -1, fault_at = -1, done_ch = 0;
  int         bz_from = 1, bz_to = 0; // edges at which the wrapper shows busy
  int         next_b = 2;             // busy length for the next conversion, 0 = wrapper ignores it
  bit         m_pend[2], m_ov[2], m_done[2];
  logic [9:0] m_hold[2];
  bit         m_trig, m_ch, m_fault, m_last;
  logic [9:0] m_din;

  function automatic logic busy_at(input int edge_idx);
    return (edge_idx >= bz_from) && (edge_idx <= bz_to);
  endfunction

  function automatic logic [18:0] model_vec();
    return pk(m_trig, m_ch, m_din, m_pend[0], m_pend[1], m_done[0], m_done[1], m_ov[0], m_ov[1], m_fault);
  endfunction

  task automatic model_reset();
    for (int n = 0; n < 2; n++) begin
      m_pend[n] = 0; m_ov[n] = 0; m_done[n] = 0; m_hold[n] = 10'd0;
    end
    m_trig = 0; m_ch = 0; m_din = 10'd0; m_fault = 0; m_last = 1;
    free_at = 0; done_at = -1; fault_at = -1;
  endtask

  task automatic model_edge(input logic w0, input logic [9:0] v0, input logic w1,
                            input logic [9:0] v1, input logic clr, input logic bsy);
    bit pend_before[2];
    bit ov_set[2];
    bit f_set;
    int granted;
    int ch;
    pend_before = m_pend;
    m_trig = 0; m_done[0] = 0; m_done[1] = 0;
    if (e == done_at) m_done[done_ch] = 1;
    f_set = (e == fault_at);
    granted = -1;
    if (e >= free_at && (m_pend[0] || m_pend[1]) && !bsy) begin
      if (m_pend[0] && m_pend[1]) begin
`ifdef DAC_SCHED_ROUND_ROBIN_EN
        ch = m_last ? 0 : 1;
`else
        ch = 0;
`endif
      end else begin
        ch = m_pend[1] ? 1 : 0;
      end
      m_last = (ch == 1);
      m_trig = 1; m_ch = (ch == 1); m_din = m_hold[ch]; m_pend[ch] = 0;
      granted = ch; done_ch = ch;
      if (next_b > 0) begin
        bz_from = e + 2; bz_to = e + 1 + next_b;
        done_at = e + next_b + 2; free_at = e + next_b + 3; fault_at = -1;
      end else begin
        bz_from = 1; bz_to = 0;
        done_at = -1; fault_at = e + 17; free_at = e + 18;
      end
    end
    ov_set[0] = w0 && pend_before[0] && (granted != 0);
    ov_set[1] = w1 && pend_before[1] && (granted != 1);
    if (w0) begin m_pend[0] = 1; m_hold[0] = v0; end
    if (w1) begin m_pend[1] = 1; m_hold[1] = v1; end
    for (int n = 0; n < 2; n++) m_ov[n] = ov_set[n] ? 1 : (clr ? 0 : m_ov[n]);
    m_fault = f_set ? 1 : (clr ? 0 : m_fault);
    e++;
  endtask

  // one clock: drive at negedge, predict, check at the following negedge
  task automatic step(input logic w0, input logic [9:0] v0, input logic w1,
                      input logic [9:0] v1, input logic clr);
    logic bsy;
    bsy = busy_at(e);
    wr0 = w0; data0 = v0; wr1 = w1; data1 = v1; clear_status = clr; dac_busy = bsy;
    model_edge(w0, v0, w1, v1, clr, bsy);
    @(posedge clk_50MHZ);
    @(negedge clk_50MHZ);
    check_vec("model", e, model_vec());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 10'd0, 1'b0, 10'd0, 1'b0);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    wr0 = 1'b0; wr1 = 1'b0; clear_status = 1'b0;
    #1;
    check_vec("reset_async", e, 19'd0);
    model_reset();
    for (int i = 0; i < 2; i++) begin
      dac_busy = busy_at(e);
      @(posedge clk_50MHZ);
      e++;
      @(negedge clk_50MHZ);
      check_vec("reset_hold", e, 19'd0);
    end
    reset_n = 1'b1;
  endtask

  // ---------------- fixed vector table ----------------
  typedef struct {
    logic       w0;
    logic [9:0] d0;
    logic       w1;
    logic [9:0] d1;
    logic       clr;
    logic       busy;
    logic [18:0] exp;
  } vec_t;

  vec_t tbl[19];

  initial begin
    int q_ch[$];
    int ch1_cnt;
    logic [9:0] r0, r1;

    tbl[0]  = '{1'b1, 10'h155, 1'b0, 10'h000, 1'b0, 1'b0, pk(0,0,10'h000,1,0,0,0,0,0,0)};
    tbl[1]  = '{1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b0, pk(1,0,10'h155,0,0,0,0,0,0,0)};
    tbl[2]  = '{1'b0, 10'h000, 1'b1, 10'h3FF, 1'b0, 1'b0, pk(0,0,10'h155,0,1,0,0,0,0,0)};
    tbl[3]  = '{1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b1, pk(0,0,10'h155,0,1,0,0,0,0,0)};
    tbl[4]  = '{1'b0, 10'h000, 1'b1, 10'h2AA, 1'b0, 1'b1, pk(0,0,10'h155,0,1,0,0,0,1,0)};
    tbl[5]  = '{1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b0, pk(0,0,10'h155,0,1,1,0,0,1,0)};
    tbl[6]  = '{1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b0, pk(1,1,10'h2AA,0,0,0,0,0,1,0)};
    tbl[7]  = '{1'b0, 10'h000, 1'b0, 10'h000, 1'b1, 1'b0, pk(0,1,10'h2AA,0,0,0,0,0,0,0)};
    tbl[8]  = '{1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b1, pk(0,1,10'h2AA,0,0,0,0,0,0,0)};
    tbl[9]  = '{1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b0, pk(0,1,10'h2AA,0,0,0,1,0,0,0)};
    tbl[10] = '{1'b1, 10'h001, 1'b0, 10'h000, 1'b0, 1'b0, pk(0,1,10'h2AA,1,0,0,0,0,0,0)};
    tbl[11] = '{1'b1, 10'h002, 1'b0, 10'h000, 1'b0, 1'b0, pk(1,0,10'h001,1,0,0,0,0,0,0)};
    tbl[12] = '{1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b0, pk(0,0,10'h001,1,0,0,0,0,0,0)};
    tbl[13] = '{1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b1, pk(0,0,10'h001,1,0,0,0,0,0,0)};
    tbl[14] = '{1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b0, pk(0,0,10'h001,1,0,1,0,0,0,0)};
    tbl[15] = '{1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b0, pk(1,0,10'h002,0,0,0,0,0,0,0)};
    tbl[16] = '{1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b0, pk(0,0,10'h002,0,0,0,0,0,0,0)};
    tbl[17] = '{1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b1, pk(0,0,10'h002,0,0,0,0,0,0,0)};
    tbl[18] = '{1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b0, pk(0,0,10'h002,0,0,1,0,0,0,0)};

    model_reset();
    repeat (3) @(posedge clk_50MHZ);
    @(negedge clk_50MHZ);
    reset_n = 1'b1;
    check_vec("reset_values", 0, 19'd0);

    for (int i = 0; i < 19; i++) begin
      wr0 = tbl[i].w0; data0 = tbl[i].d0; wr1 = tbl[i].w1; data1 = tbl[i].d1;
      clear_status = tbl[i].clr; dac_busy = tbl[i].busy;
      @(posedge clk_50MHZ);
      @(negedge clk_50MHZ);
      check_vec("table", i, tbl[i].exp);
    end
    dac_busy = 1'b0;
    @(negedge clk_50MHZ);
    apply_reset();

    // long conversion, single request
    next_b = 100;
    step(1'b1, 10'h155, 1'b0, 10'h000, 1'b0);
    idle(106);

    // tied pairs: order of issue
    next_b = 2;
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 10'h001, 1'b1, 10'h3FF, 1'b0);
      for (int i = 0; i < 14; i++) begin
        step(1'b0, 10'd0, 1'b0, 10'd0, 1'b0);
        if (dac_trigger) q_ch.push_back(int'(dac_channel));
      end
    end
    checks++;
    if (q_ch.size() != 6) begin
      errors++;
      $display("FAIL pair_order: got %0d triggers, expected 6", q_ch.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        if (q_ch[i] != (i % 2)) begin
          errors++;
          $display("FAIL pair_order[%0d]: got channel %0d expected %0d", i, q_ch[i], i % 2);
        end
      end
    end

    // continuous channel-0 traffic against one channel-1 request
    next_b = 1;
    ch1_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      step(1'b1, 10'($urandom), (i == 0), 10'h1C3, 1'b0);
      if (dac_trigger && dac_channel) ch1_cnt++;
    end
    checks++;
`ifdef DAC_SCHED_ROUND_ROBIN_EN
    if (ch1_cnt != 1) begin
      errors++;
      $display("FAIL rr_share: got %0d channel-1 grants, expected 1", ch1_cnt);
    end
`else
    if (ch1_cnt != 0) begin
      errors++;
      $display("FAIL starve: got %0d channel-1 grants, expected 0", ch1_cnt);
    end
`endif
    idle(12);

    // overrun while busy, then clear_status
    next_b = 20;
    step(1'b1, 10'h005, 1'b0, 10'd0, 1'b0);
    step(1'b0, 10'h000, 1'b0, 10'd0, 1'b0);
    step(1'b1, 10'h010, 1'b0, 10'd0, 1'b0);
    step(1'b1, 10'h020, 1'b0, 10'd0, 1'b0);
    idle(50);
    step(1'b0, 10'h000, 1'b0, 10'd0, 1'b1);

    // wrapper never raises busy, then a following request still issues
    next_b = 0;
    step(1'b1, 10'h011, 1'b0, 10'd0, 1'b0);
    step(1'b0, 10'h000, 1'b1, 10'h022, 1'b0);
    next_b = 3;
    idle(30);
    step(1'b0, 10'h000, 1'b0, 10'd0, 1'b1);

    // reset during WAIT_DONE with the wrapper still settling
    next_b = 30;
    step(1'b1, 10'h3AB, 1'b0, 10'd0, 1'b0);
    idle(8);
    apply_reset();
    next_b = 2;
    step(1'b1, 10'h0AA, 1'b0, 10'd0, 1'b0);
    idle(30);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      next_b = ($urandom_range(0, 19) == 0) ? 0 : int'($urandom_range(1, 6));
      r0 = 10'($urandom);
      r1 = 10'($urandom);
      step(($urandom_range(0, 3) == 0), r0, ($urandom_range(0, 3) == 0), r1,
           ($urandom_range(0, 15) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
